// File: rtl/lcd_bus_scheduler.sv
// Arbitrates two byte requesters onto a 4-bit HD44780 bus: runs the power-on
// init nibbles, then splits each granted byte into EN-timed nibbles plus a settle wait.
module lcd_bus_scheduler #(
  parameter int unsigned EN_CYCLES = 800,
  parameter int unsigned CMD_WAIT  = 2000,
  parameter int unsigned LONG_WAIT = 60000,
  parameter int unsigned INIT_WAIT = 600000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid_i,
  input  logic       a_rs_i,
  input  logic [7:0] a_byte_i,
  output logic       a_ready_o,
  input  logic       b_valid_i,
  input  logic       b_rs_i,
  input  logic [7:0] b_byte_i,
  output logic       b_ready_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic [3:0] lcd_data_o
);

  localparam int unsigned MaxA   = (INIT_WAIT > LONG_WAIT) ? INIT_WAIT : LONG_WAIT;
  localparam int unsigned MaxB   = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
  localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] InitLen = CntW'(INIT_WAIT - 1);
  localparam logic [CntW-1:0] EnLen   = CntW'(EN_CYCLES - 1);
  localparam logic [CntW-1:0] LongLen = CntW'(LONG_WAIT - 1);
  localparam logic [CntW-1:0] CmdLen  = CntW'(CMD_WAIT - 1);

  typedef enum logic [3:0] {
    StInitDly, StInitSet, StInitEn, StInitGap, StIdle,
    StSetH, StEnH, StHoldH, StSetL, StEnL, StWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      k_q, k_d;
  logic            rs_q, rs_d;
  logic [7:0]      byte_q, byte_d;
  logic            prio_b_q, prio_b_d;
  logic            init_done_q, init_done_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic            lcd_en_q, lcd_en_d;
  logic [3:0]      lcd_data_q, lcd_data_d;
  logic            gnt_a, gnt_b, long_wait;

  // prio_b_q set means B wins a tie; cleared at reset so A is favoured.
  assign gnt_a = a_valid_i & (~b_valid_i | ~prio_b_q);
  assign gnt_b = b_valid_i & ~gnt_a;
  assign long_wait = ~rs_q & (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rs_d        = rs_q;
    byte_d      = byte_q;
    prio_b_d    = prio_b_q;
    init_done_d = init_done_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
    a_ready_o   = 1'b0;
    b_ready_o   = 1'b0;

    case (state_q)
      StInitDly: if (cnt_q == '0) state_d = StInitSet;
      StInitSet: state_d = StInitEn;
      StInitEn:  if (cnt_q == '0) state_d = StInitGap;
      StInitGap: begin
        if (cnt_q == '0) begin
          if (k_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = StInitSet;
          end
        end
      end
      StIdle: begin
        if (init_done_q) begin
          a_ready_o = gnt_a;
          b_ready_o = gnt_b;
          if (gnt_a || gnt_b) begin
            rs_d     = gnt_a ? a_rs_i : b_rs_i;
            byte_d   = gnt_a ? a_byte_i : b_byte_i;
            prio_b_d = gnt_a;
            state_d  = StSetH;
          end
        end
      end
      StSetH:  state_d = StEnH;
      StEnH:   if (cnt_q == '0) state_d = StHoldH;
      StHoldH: if (cnt_q == '0) state_d = StSetL;
      StSetL:  state_d = StEnL;
      StEnL:   if (cnt_q == '0) state_d = StWait;
      StWait:  if (cnt_q == '0) state_d = StIdle;
      default: state_d = StInitDly;
    endcase

    // Counter is reloaded with (length - 1) whenever a new state is entered.
    if (state_d != state_q) begin
      case (state_d)
        StInitDly:                        cnt_d = InitLen;
        StInitEn, StEnH, StHoldH, StEnL:  cnt_d = EnLen;
        StInitGap:                        cnt_d = LongLen;
        StWait:                           cnt_d = long_wait ? LongLen : CmdLen;
        default:                          cnt_d = '0;
      endcase
    end

    // Bus pins are registered from the next state so they change with the state.
    lcd_en_d   = (state_d == StInitEn) || (state_d == StEnH) || (state_d == StEnL);
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    case (state_d)
      StInitSet: begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = (k_d == 2'd3) ? 4'h2 : 4'h3;
      end
      StSetH: begin
        lcd_rs_d   = rs_d;
        lcd_data_d = byte_d[7:4];
      end
      StSetL:  lcd_data_d = byte_q[3:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInitDly;
      cnt_q       <= InitLen;
      k_q         <= 2'd0;
      rs_q        <= 1'b0;
      byte_q      <= 8'h00;
      prio_b_q    <= 1'b0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_data_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      rs_q        <= rs_d;
      byte_q      <= byte_d;
      prio_b_q    <= prio_b_d;
      init_done_q <= init_done_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
      lcd_data_q  <= lcd_data_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign init_done_o = init_done_q;
  assign lcd_rs_o    = lcd_rs_q;
  assign lcd_en_o    = lcd_en_q;
  assign lcd_data_o  = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: expected {rs,nibble} pairs are queued
// when stimulus is issued and popped by a bus monitor on every EN rising edge.
module tb_lcd_bus_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_rs, b_valid, b_rs;
  logic [7:0] a_byte, b_byte;
  logic       a_ready, b_ready, busy, init_done, lcd_rs, lcd_en;
  logic [3:0] lcd_data;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [4:0] exp_q[$];

  lcd_bus_scheduler #(
    .EN_CYCLES(4),
    .CMD_WAIT (10),
    .LONG_WAIT(50),
    .INIT_WAIT(100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid_i  (a_valid),
    .a_rs_i     (a_rs),
    .a_byte_i   (a_byte),
    .a_ready_o  (a_ready),
    .b_valid_i  (b_valid),
    .b_rs_i     (b_rs),
    .b_byte_i   (b_byte),
    .b_ready_o  (b_ready),
    .busy_o     (busy),
    .init_done_o(init_done),
    .lcd_rs_o   (lcd_rs),
    .lcd_en_o   (lcd_en),
    .lcd_data_o (lcd_data)
  );

  always #5 clk = ~clk;

  // Bus monitor: nibble scoreboard, EN width, stability while EN high, ready exclusivity.
  logic       en_prev = 1'b0;
  int         hi_cnt  = 0;
  logic [4:0] held;
  logic [4:0] want;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
      hi_cnt  = 0;
    end else begin
      if (a_ready || b_ready) begin
        checks++;
        if (a_ready && b_ready) begin
          errors++;
          $display("FAIL ready_exclusive got a=%b b=%b want not both", a_ready, b_ready);
        end
      end
      if (lcd_en && !en_prev) begin
        pulses++;
        held   = {lcd_rs, lcd_data};
        hi_cnt = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_nibble got %h want none", held);
        end else begin
          want = exp_q.pop_front();
          if (held !== want) begin
            errors++;
            $display("FAIL nibble got rs/data %h want %h", held, want);
          end
        end
      end else if (lcd_en) begin
        hi_cnt++;
        checks++;
        if ({lcd_rs, lcd_data} !== held) begin
          errors++;
          $display("FAIL bus_stable got %h want %h", {lcd_rs, lcd_data}, held);
        end
      end else if (en_prev) begin
        checks++;
        if (hi_cnt != 4) begin
          errors++;
          $display("FAIL en_width got %0d want 4", hi_cnt);
        end
      end
      en_prev = lcd_en;
    end
  end

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  // Reset, release, and check the whole init sequence timing.
  task automatic reset_and_init(input int exp_left);
    int n;
    int en_early;
    int bad_rdy;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) exp_q.push_back({1'b0, 4'h3});
    exp_q.push_back({1'b0, 4'h2});
    repeat (3) @(negedge clk);
    checks++;
    if (lcd_en !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 4'h0 || busy !== 1'b1 ||
        init_done !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got en=%b rs=%b d=%h busy=%b done=%b ra=%b rb=%b want 0,0,0,1,0,0,0",
               lcd_en, lcd_rs, lcd_data, busy, init_done, a_ready, b_ready);
    end
    rst_n    = 1'b1;
    pulses   = 0;
    n        = 0;
    en_early = 0;
    bad_rdy  = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (n <= 100 && lcd_en) en_early++;
      if (n == 101) begin
        checks++;
        if (lcd_en !== 1'b1) begin
          errors++;
          $display("FAIL first_en_rise got en=%b want 1 at cycle 101", lcd_en);
        end
      end
      if (!init_done && (a_ready || b_ready)) bad_rdy++;
    end
    checks++;
    if (en_early != 0) begin
      errors++;
      $display("FAIL init_delay got %0d en-high cycles want 0", en_early);
    end
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL ready_before_init got %0d want 0", bad_rdy);
    end
    // 100 delay + 4 * (1 set + 4 en + 50 gap) = 320 cycles to init_done.
    checks++;
    if (n != 320) begin
      errors++;
      $display("FAIL init_length got %0d want 320", n);
    end
    checks++;
    if (busy !== 1'b0 || pulses != 4 || exp_q.size() != exp_left) begin
      errors++;
      $display("FAIL init_end got busy=%b pulses=%0d left=%0d want 0 4 %0d",
               busy, pulses, exp_q.size(), exp_left);
    end
    checks++;
    if (a_ready !== a_valid) begin
      errors++;
      $display("FAIL ready_at_init_done got %b want %b", a_ready, a_valid);
    end
  endtask

  // Present one byte from a requester and wait for its transfer.
  task automatic start(input bit sel, input logic rs, input logic [7:0] b);
    int  n;
    bit  got;
    push_byte(rs, b);
    @(posedge clk);
    #1;
    if (!sel) begin a_rs = rs; a_byte = b; a_valid = 1'b1; end
    else      begin b_rs = rs; b_byte = b; b_valid = 1'b1; end
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = sel ? b_ready : a_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout got no ready want ready for %h", b);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_idle(output int bc);
    int n;
    bc = 0;
    n  = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 500) begin
      bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic xfer(input bit sel, input logic rs, input logic [7:0] b, input int exp_busy);
    int bc;
    start(sel, rs, b);
    wait_idle(bc);
    checks++;
    if (bc != exp_busy) begin
      errors++;
      $display("FAIL busy_length byte %h got %0d want %0d", b, bc, exp_busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL nibbles_left byte %h got %0d want 0", b, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_and_init(0);
  endtask

  task automatic test_data_write();
    xfer(1'b0, 1'b1, 8'h41, 24);
  endtask

  task automatic test_cmd_wait();
    xfer(1'b0, 1'b0, 8'h01, 64);
    xfer(1'b0, 1'b0, 8'h0C, 24);
    xfer(1'b1, 1'b0, 8'h02, 64);
    xfer(1'b1, 1'b1, 8'h03, 24);
  endtask

  task automatic test_round_robin();
    int grants;
    int n;
    int bc;
    bit exp_b;
    reset_and_init(0);
    push_byte(1'b1, 8'h5A);
    push_byte(1'b1, 8'hC3);
    push_byte(1'b1, 8'h5A);
    push_byte(1'b1, 8'hC3);
    @(posedge clk);
    #1;
    a_rs = 1'b1; a_byte = 8'h5A; a_valid = 1'b1;
    b_rs = 1'b1; b_byte = 8'hC3; b_valid = 1'b1;
    grants = 0;
    n      = 0;
    while (grants < 4 && n < 1000) begin
      @(negedge clk);
      n++;
      if (a_ready || b_ready) begin
        exp_b = (grants % 2) == 1;
        checks++;
        if (b_ready !== exp_b || a_ready !== !exp_b) begin
          errors++;
          $display("FAIL rr_order grant %0d got a=%b b=%b want b=%b", grants, a_ready, b_ready, exp_b);
        end
        grants++;
      end
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (grants != 4) begin
      errors++;
      $display("FAIL rr_grants got %0d want 4", grants);
    end
    wait_idle(bc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_nibbles_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_valid_during_init();
    int bc;
    a_rs = 1'b1; a_byte = 8'h37; a_valid = 1'b1;
    reset_and_init(0);
    push_byte(1'b1, 8'h37);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    wait_idle(bc);
    checks++;
    if (bc != 24 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL early_valid got busy=%0d left=%0d want 24 0", bc, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start(1'b0, 1'b0, 8'h80);
    n = 0;
    while (lcd_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lcd_en !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got en=%b done=%b busy=%b want 0 0 1", lcd_en, init_done, busy);
    end
    reset_and_init(0);
    repeat (20) @(negedge clk);
    checks++;
    if (pulses != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL aborted_byte got pulses=%0d left=%0d want 4 0", pulses, exp_q.size());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_rs    = 1'b0;
    a_byte  = 8'h00;
    b_valid = 1'b0;
    b_rs    = 1'b0;
    b_byte  = 8'h00;
    test_reset();
    test_data_write();
    test_cmd_wait();
    test_round_robin();
    test_valid_during_init();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
